// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    // Fetch controller states: normal fetching, waiting with a buffered word,
    // and draining a request made stale by a redirect.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, memory request handshake, one-entry
// hold buffer and the IF/ID pipeline register.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic        stall,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        ifid_valid,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  ifid_inst_q, ifid_inst_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;
    logic [31:0]  hold_inst_q, hold_inst_d;
    logic [31:0]  hold_pc4_q, hold_pc4_d;
    logic [31:0]  req_pc4;

    assign pc4        = pc_q + PC_INC;
    assign req_pc4    = addr_q + PC_INC;
    assign pc         = pc_q;
    assign imem_addr  = addr_q;
    // A request is outstanding in FETCH and DRAIN; reset silences it at once.
    assign imem_req   = ~rst & (state_q != HOLD);
    assign ifid_valid = ifid_valid_q;
    assign ifid_inst  = ifid_inst_q;
    assign ifid_pc4   = ifid_pc4_q;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= '0;
            ifid_pc4_q   <= '0;
            hold_inst_q  <= '0;
            hold_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc4_q   <= ifid_pc4_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc4_q   <= hold_pc4_d;
        end
    end

    // Next-state logic: redirect beats stall; a redirect with the request
    // still in flight waits in DRAIN so the memory sees a stable request.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc4_d   = ifid_pc4_q;
        hold_inst_d  = hold_inst_q;
        hold_pc4_d   = hold_pc4_q;
        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d         = npc;
                    ifid_valid_d = 1'b0;
                    if (imem_ack) begin
                        addr_d = npc;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_d   = pc4;
                    addr_d = pc4;
                    if (!ifid_valid_q || !stall) begin
                        ifid_inst_d  = imem_rdata;
                        ifid_pc4_d   = req_pc4;
                        ifid_valid_d = 1'b1;
                    end else begin
                        hold_inst_d = imem_rdata;
                        hold_pc4_d  = req_pc4;
                        state_d     = HOLD;
                    end
                end else if (ifid_valid_q && !stall) begin
                    ifid_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d         = npc;
                    addr_d       = npc;
                    ifid_valid_d = 1'b0;
                    hold_inst_d  = '0;
                    hold_pc4_d   = '0;
                    state_d      = FETCH;
                end else if (!stall) begin
                    ifid_inst_d = hold_inst_q;
                    ifid_pc4_d  = hold_pc4_q;
                    state_d     = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_d = npc;
                end
                if (imem_ack) begin
                    addr_d  = redirect ? npc : pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a queue-based transaction model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, redirect, stall, imem_ack;
    logic [31:0] npc, imem_rdata;
    logic [31:0] pc, pc4, imem_addr, ifid_inst, ifid_pc4;
    logic        imem_req, ifid_valid;
    logic [31:0] d2_pc, d2_pc4, d2_imem_addr, d2_ifid_inst, d2_ifid_pc4;
    logic        d2_imem_req, d2_ifid_valid;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .npc(npc), .redirect(redirect), .stall(stall),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .pc4(pc4),
        .imem_req(imem_req), .imem_addr(imem_addr), .ifid_valid(ifid_valid),
        .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst), .npc(npc), .redirect(redirect), .stall(stall),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(d2_pc), .pc4(d2_pc4),
        .imem_req(d2_imem_req), .imem_addr(d2_imem_addr), .ifid_valid(d2_ifid_valid),
        .ifid_inst(d2_ifid_inst), .ifid_pc4(d2_ifid_pc4)
    );

    // Model: delivered-but-unconsumed words in order (IF/ID first, hold second).
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc, m_addr;
    bit          m_stale;
    bit          m_zero;
    bit          chk_en = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the transaction model.
    task automatic model_edge(input bit r, input bit rd, input logic [31:0] n,
                              input bit st, input bit ack, input logic [31:0] rdata);
        bit req;
        if (r) begin
            mq.delete();
            m_pc    = 32'h0;
            m_addr  = 32'h0;
            m_stale = 1'b0;
            m_zero  = 1'b1;
            return;
        end
        req = (mq.size() < 2);
        if (rd) begin
            m_pc = n;
            mq.delete();
            if (!req) begin
                m_addr = n;
            end else if (ack) begin
                m_addr  = n;
                m_stale = 1'b0;
            end else begin
                m_stale = 1'b1;
            end
        end else begin
            if (mq.size() > 0 && !st) void'(mq.pop_front());
            if (req && ack) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_addr  = m_pc;
                end else begin
                    mq.push_back('{inst: rdata, pc4: m_addr + 32'd4});
                    m_addr = m_addr + 32'd4;
                    m_pc   = m_addr;
                    m_zero = 1'b0;
                end
            end
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check1("imem_req", imem_req, (rst === 1'b0) && (mq.size() < 2));
            check32("imem_addr", imem_addr, m_addr);
            check32("pc", pc, m_pc);
            check32("pc4", pc4, m_pc + 32'd4);
            check1("ifid_valid", ifid_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                check32("ifid_inst", ifid_inst, mq[0].inst);
                check32("ifid_pc4", ifid_pc4, mq[0].pc4);
            end else if (m_zero) begin
                check32("ifid_inst_rst", ifid_inst, 32'h0);
                check32("ifid_pc4_rst", ifid_pc4, 32'h0);
            end
        end
    end

    task automatic step(input bit r, input bit rd, input logic [31:0] n,
                        input bit st, input bit ack);
        rst        = r;
        redirect   = rd;
        npc        = n;
        stall      = st;
        imem_ack   = ack;
        imem_rdata = ack ? mem_word(m_addr) : 32'hDEAD_BEEF;
        @(posedge clk);
        model_edge(r, rd, n, st, ack, imem_rdata);
        chk_en = 1'b1;
        #1;
    endtask

    initial begin
        m_pc = '0; m_addr = '0; m_stale = 1'b0; m_zero = 1'b1;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", ifid_valid, 1'b0);
        check32("rst_addr", imem_addr, 32'h0);
        check32("rst_inst", ifid_inst, 32'h0);
        check32("wrap_rst_pc", d2_pc, 32'hFFFF_FFFC);
        check32("wrap_rst_addr", d2_imem_addr, 32'hFFFF_FFFC);

        // First cycle out of reset presents the reset PC
        rst = 1'b0;
        #1;
        check1("first_req", imem_req, 1'b1);
        check32("first_addr", imem_addr, 32'h0);

        // Back-to-back acks, no stall
        for (int unsigned k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 1);
            check32("seq_addr", imem_addr, 32'd4 * (k + 1));
            check32("seq_ifid_pc4", ifid_pc4, 32'd4 * (k + 1));
            if (k == 0) begin
                check32("wrap_ifid_pc4", d2_ifid_pc4, 32'h0);
                check32("wrap_addr", d2_imem_addr, 32'h0);
                check32("wrap_inst", d2_ifid_inst, mem_word(32'h0));
            end
        end

        // Stall with a full IF/ID: word @8 parks in the hold buffer
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        check1("hold_req", imem_req, 1'b0);
        check32("hold_ifid_pc4", ifid_pc4, 32'd8);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        check32("unhold_inst", ifid_inst, mem_word(32'd8));
        check32("unhold_pc4", ifid_pc4, 32'd12);
        check1("unhold_req", imem_req, 1'b1);
        check32("unhold_addr", imem_addr, 32'd12);
        step(0, 0, 0, 0, 0);
        check1("consume_valid", ifid_valid, 1'b0);

        // Redirect with request at 0x10 in flight, ack two cycles later
        step(0, 0, 0, 0, 1);
        step(0, 1, 32'h400, 0, 0);
        check1("drain_valid", ifid_valid, 1'b0);
        check32("drain_addr", imem_addr, 32'h10);
        check32("drain_pc", pc, 32'h400);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check1("drained_valid", ifid_valid, 1'b0);
        check32("drained_addr", imem_addr, 32'h400);
        step(0, 0, 0, 0, 1);
        check32("after_drain_pc4", ifid_pc4, 32'h404);

        // Second redirect while draining only moves the PC
        step(0, 1, 32'h200, 0, 0);
        step(0, 1, 32'h300, 0, 0);
        step(0, 0, 0, 0, 1);
        check32("redrain_addr", imem_addr, 32'h300);

        // Redirect and ack in the same cycle
        step(0, 0, 0, 0, 1);
        step(0, 1, 32'h80, 0, 1);
        check1("redir_ack_valid", ifid_valid, 1'b0);
        check32("redir_ack_addr", imem_addr, 32'h80);
        step(0, 0, 0, 0, 1);
        check32("redir_ack_pc4", ifid_pc4, 32'h84);

        // Redirect while holding
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h100, 1, 0);
        check1("hold_redir_valid", ifid_valid, 1'b0);
        check32("hold_redir_addr", imem_addr, 32'h100);

        // Reset while holding under stall
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 1, 0);
        check1("hold_rst_valid", ifid_valid, 1'b0);
        check32("hold_rst_pc", pc, 32'h0);
        check1("hold_rst_req", imem_req, 1'b0);

        // Late ack during reset is ignored
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check32("post_rst_pc4", ifid_pc4, 32'h4);
        check32("post_rst_inst", ifid_inst, mem_word(32'h0));

        // Mixed traffic
        for (int unsigned i = 0; i < 60; i++) begin
            step(0, (i % 11) == 5, 32'h1000 + 32'(i) * 32'd16,
                 ((i % 4) == 1) || ((i % 7) == 3), (i % 3) != 2);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
